// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: read-owner tag and the
// per-port request bundle that is muxed onto the memory interface.
package mem_arb_pkg;

  // Halfword address width of the shared memory.
  localparam int MEM_ADDR_WIDTH = 12;

  // Which port a pending read response belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  // One access as presented by a requester.
  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [15:0]               wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way arbiter. Bit 0 is port A, bit 1 is port B. The grant is
// combinational so a requester is accepted in the cycle it asks; only the
// "who won last" history is registered. Grants are held low during reset.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 when port B won the most recent grant; reset value lets A win first.
  logic       r_last_b;
  logic [1:0] w_gnt;

  // Choose the winner: a lone requester wins, a conflict goes to A under
  // fixed priority and otherwise to the port that did not win last time.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst_n) begin
      w_gnt = 2'b00;
    end else begin
      case (req)
        2'b01: w_gnt = 2'b01;
        2'b10: w_gnt = 2'b10;
        2'b11: begin
          if (FIXED_PRIO || r_last_b) begin
            w_gnt = 2'b01;
          end else begin
            w_gnt = 2'b10;
          end
        end
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign gnt = w_gnt;

  // Track the last granted port; idle cycles leave the history untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_gnt[0]) begin
      r_last_b <= 1'b0;
    end else if (w_gnt[1]) begin
      r_last_b <= 1'b1;
    end else begin
      r_last_b <= r_last_b;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous 16-bit memory between an instruction
// fetch port (A) and a data port (B). At most one access per clock; read
// data returns one cycle after the grant and is steered to the port that
// issued the read via a registered owner tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [15:0]           a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [15:0]           a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [15:0]           b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [15:0]           b_rdata,
  output logic                  mem_en,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_din,
  input  logic [15:0]           mem_dout
);

  logic [1:0] w_gnt;
  mem_req_t   w_a_req;
  mem_req_t   w_b_req;
  mem_req_t   w_sel_req;
  owner_t     w_rd_owner_nxt;
  owner_t     r_rd_owner;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_req, a_req}),
    .gnt   (w_gnt)
  );

  // Bundle each port's request and pick the granted one for the memory.
  always_comb begin
    w_a_req   = '{we: a_we, addr: MEM_ADDR_WIDTH'(a_addr), wdata: a_wdata};
    w_b_req   = '{we: b_we, addr: MEM_ADDR_WIDTH'(b_addr), wdata: b_wdata};
    w_sel_req = w_a_req;
    if (w_gnt[1]) begin
      w_sel_req = w_b_req;
    end else begin
      w_sel_req = w_a_req;
    end
  end

  assign a_gnt     = w_gnt[0];
  assign b_gnt     = w_gnt[1];
  assign mem_en    = |w_gnt;
  assign mem_wr_en = mem_en &  w_sel_req.we;
  assign mem_rd_en = mem_en & ~w_sel_req.we;
  assign mem_addr  = ADDR_WIDTH'(w_sel_req.addr);
  assign mem_din   = w_sel_req.wdata;

  // Tag a granted read with its port so the response can be steered next cycle.
  always_comb begin
    w_rd_owner_nxt = OWN_NONE;
    if (w_gnt[0] && !a_we) begin
      w_rd_owner_nxt = OWN_A;
    end else if (w_gnt[1] && !b_we) begin
      w_rd_owner_nxt = OWN_B;
    end else begin
      w_rd_owner_nxt = OWN_NONE;
    end
  end

  // Response pipeline stage; reset cancels any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= OWN_NONE;
    end else begin
      r_rd_owner <= w_rd_owner_nxt;
    end
  end

  assign a_rvalid = (r_rd_owner == OWN_A);
  assign b_rvalid = (r_rd_owner == OWN_B);
  assign a_rdata  = mem_dout;
  assign b_rdata  = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one round-robin and one fixed-priority
// instance, each with its own behavioural memory, driven by per-port
// command queues. A reference model predicts grants and read data; read
// responses go to a scoreboard that an independent monitor drains.
module tb_mem_port_arbiter;

  typedef struct {
    bit          idle;
    bit          we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // index [d][p]: d=0 round-robin instance, d=1 fixed-priority; p=0 A, p=1 B
  logic        req_s    [2][2];
  logic        we_s     [2][2];
  logic [11:0] addr_s   [2][2];
  logic [15:0] wdata_s  [2][2];
  logic        gnt_s    [2][2];
  logic        rvalid_s [2][2];
  logic [15:0] rdata_s  [2][2];
  logic        mem_en_s   [2];
  logic        mem_rd_s   [2];
  logic        mem_wr_s   [2];
  logic [11:0] mem_addr_s [2];
  logic [15:0] mem_din_s  [2];
  logic [15:0] mem_dout_s [2];

  mem_port_arbiter #(.ADDR_WIDTH(12), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_req(req_s[0][0]), .a_we(we_s[0][0]), .a_addr(addr_s[0][0]), .a_wdata(wdata_s[0][0]),
    .a_gnt(gnt_s[0][0]), .a_rvalid(rvalid_s[0][0]), .a_rdata(rdata_s[0][0]),
    .b_req(req_s[0][1]), .b_we(we_s[0][1]), .b_addr(addr_s[0][1]), .b_wdata(wdata_s[0][1]),
    .b_gnt(gnt_s[0][1]), .b_rvalid(rvalid_s[0][1]), .b_rdata(rdata_s[0][1]),
    .mem_en(mem_en_s[0]), .mem_rd_en(mem_rd_s[0]), .mem_wr_en(mem_wr_s[0]),
    .mem_addr(mem_addr_s[0]), .mem_din(mem_din_s[0]), .mem_dout(mem_dout_s[0])
  );

  mem_port_arbiter #(.ADDR_WIDTH(12), .FIXED_PRIO(1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .a_req(req_s[1][0]), .a_we(we_s[1][0]), .a_addr(addr_s[1][0]), .a_wdata(wdata_s[1][0]),
    .a_gnt(gnt_s[1][0]), .a_rvalid(rvalid_s[1][0]), .a_rdata(rdata_s[1][0]),
    .b_req(req_s[1][1]), .b_we(we_s[1][1]), .b_addr(addr_s[1][1]), .b_wdata(wdata_s[1][1]),
    .b_gnt(gnt_s[1][1]), .b_rvalid(rvalid_s[1][1]), .b_rdata(rdata_s[1][1]),
    .mem_en(mem_en_s[1]), .mem_rd_en(mem_rd_s[1]), .mem_wr_en(mem_wr_s[1]),
    .mem_addr(mem_addr_s[1]), .mem_din(mem_din_s[1]), .mem_dout(mem_dout_s[1])
  );

  // Preload contents of every memory location.
  function automatic logic [15:0] init_val(input logic [11:0] a);
    case (a)
      12'h010: return 16'hBEEF;
      12'h001: return 16'h0A0A;
      12'h002: return 16'h0B0B;
      default: return {4'hC, a};
    endcase
  endfunction

  // Behavioural single-port memories with registered read data.
  logic [15:0] env_mem  [2][4096];
  bit          env_seen [2][4096];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en_s[d] === 1'b1) begin
        if (mem_wr_s[d] === 1'b1) begin
          env_mem[d][mem_addr_s[d]]  <= mem_din_s[d];
          env_seen[d][mem_addr_s[d]] <= 1'b1;
        end
        if (mem_rd_s[d] === 1'b1) begin
          mem_dout_s[d] <= env_seen[d][mem_addr_s[d]] ? env_mem[d][mem_addr_s[d]]
                                                       : init_val(mem_addr_s[d]);
        end
      end
    end
  end

  // Reference model state
  logic [15:0] m_mem  [2][4096];
  bit          m_seen [2][4096];
  bit          m_last_b [2];
  cmd_t        cmd_q [4][$];
  exp_t        exp_q [4][$];
  bit          active [4];
  cmd_t        cur [4];
  int          wait_cnt [4];
  int          cyc;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Present the next queued command on every idle port; busy ports hold.
  task automatic drive();
    cmd_t c;
    for (int i = 0; i < 4; i++) begin
      if (!active[i] && cmd_q[i].size() > 0) begin
        c = cmd_q[i].pop_front();
        if (!c.idle) begin
          active[i]   = 1'b1;
          cur[i]      = c;
          wait_cnt[i] = 0;
        end
      end
      req_s[i >> 1][i & 1] = active[i];
      if (active[i]) begin
        we_s[i >> 1][i & 1]    = cur[i].we;
        addr_s[i >> 1][i & 1]  = cur[i].addr;
        wdata_s[i >> 1][i & 1] = cur[i].wdata;
      end
    end
  endtask

  // Predict this cycle's grant from the arbitration rules and compare.
  task automatic model();
    logic [1:0] eg;
    int         p;
    int         i;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        eg          = 2'b00;
        m_last_b[d] = 1'b1;
      end else if (req_s[d][0] && req_s[d][1]) begin
        eg = (d == 1 || m_last_b[d]) ? 2'b01 : 2'b10;
      end else begin
        eg = {req_s[d][1], req_s[d][0]};
      end
      chk($sformatf("a_gnt[%0d]", d), 32'(gnt_s[d][0]), 32'(eg[0]));
      chk($sformatf("b_gnt[%0d]", d), 32'(gnt_s[d][1]), 32'(eg[1]));
      chk($sformatf("mem_en[%0d]", d), 32'(mem_en_s[d]), 32'(eg != 2'b00));
      if (!rst_n) begin
        chk($sformatf("rst_rd_en[%0d]", d), 32'(mem_rd_s[d]), 32'd0);
        chk($sformatf("rst_wr_en[%0d]", d), 32'(mem_wr_s[d]), 32'd0);
      end
      if (eg != 2'b00) begin
        p = eg[1] ? 1 : 0;
        i = d * 2 + p;
        chk($sformatf("mem_wr_en[%0d]", d), 32'(mem_wr_s[d]), 32'(cur[i].we));
        chk($sformatf("mem_rd_en[%0d]", d), 32'(mem_rd_s[d]), 32'(!cur[i].we));
        chk($sformatf("mem_addr[%0d]", d), 32'(mem_addr_s[d]), 32'(cur[i].addr));
        if (cur[i].we) begin
          chk($sformatf("mem_din[%0d]", d), 32'(mem_din_s[d]), 32'(cur[i].wdata));
          m_mem[d][cur[i].addr]  = cur[i].wdata;
          m_seen[d][cur[i].addr] = 1'b1;
        end else begin
          exp_q[i].push_back('{cyc: cyc,
                               data: m_seen[d][cur[i].addr] ? m_mem[d][cur[i].addr]
                                                            : init_val(cur[i].addr)});
        end
        if (d == 0) begin
          chk($sformatf("rr_wait[%0d]", p), 32'(wait_cnt[i] <= 1), 32'd1);
        end
        m_last_b[d] = (p == 1);
        active[i]   = 1'b0;
      end
      for (int q = 0; q < 2; q++) begin
        if (rst_n && active[d * 2 + q]) wait_cnt[d * 2 + q]++;
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 4; i++) begin
      if (active[i] || cmd_q[i].size() > 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_drain();
    int n;
    n = 0;
    while (!all_idle() && n < 2000) begin
      step();
      n++;
    end
    chk("drain_budget", 32'(all_idle()), 32'd1);
    step();
    step();
  endtask

  // Queue one command for port p on both instances.
  task automatic push(input int p, input bit idle, input bit we,
                      input logic [11:0] addr, input logic [15:0] wdata);
    cmd_t c;
    c = '{idle: idle, we: we, addr: addr, wdata: wdata};
    cmd_q[p].push_back(c);
    cmd_q[2 + p].push_back(c);
  endtask

  // Monitor: every cycle, each port's rvalid must match the scoreboard and
  // carry the predicted data.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_rv;
    for (int i = 0; i < 4; i++) begin
      exp_rv = (exp_q[i].size() > 0) && (exp_q[i][0].cyc == cyc - 1);
      chk($sformatf("rvalid[%0d][%0d]", i >> 1, i & 1),
          32'(rvalid_s[i >> 1][i & 1]), 32'(exp_rv));
      if (exp_rv) begin
        e = exp_q[i].pop_front();
        chk($sformatf("rdata[%0d][%0d]", i >> 1, i & 1),
            32'(rdata_s[i >> 1][i & 1]), 32'(e.data));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      active[i]   = 1'b0;
      wait_cnt[i] = 0;
      req_s[i >> 1][i & 1]   = 1'b0;
      we_s[i >> 1][i & 1]    = 1'b0;
      addr_s[i >> 1][i & 1]  = 12'h000;
      wdata_s[i >> 1][i & 1] = 16'h0000;
    end
    m_last_b[0] = 1'b1;
    m_last_b[1] = 1'b1;

    // Reset window
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single read from A
    push(0, 1'b0, 1'b0, 12'h010, 16'h0000);
    run_drain();

    // B write then back-to-back read of the same address
    push(1, 1'b0, 1'b1, 12'h020, 16'h1234);
    push(1, 1'b0, 1'b0, 12'h020, 16'h0000);
    run_drain();

    // Continuous conflict
    for (int k = 0; k < 6; k++) begin
      push(0, 1'b0, 1'b0, 12'h001, 16'h0000);
      push(1, 1'b0, 1'b0, 12'h002, 16'h0000);
    end
    run_drain();

    // Grant to A, idle gap, then a conflict
    push(0, 1'b0, 1'b0, 12'h030, 16'h0000);
    for (int k = 0; k < 3; k++) push(0, 1'b1, 1'b0, 12'h000, 16'h0000);
    push(0, 1'b0, 1'b0, 12'h031, 16'h0000);
    for (int k = 0; k < 4; k++) push(1, 1'b1, 1'b0, 12'h000, 16'h0000);
    push(1, 1'b0, 1'b0, 12'h032, 16'h0000);
    run_drain();

    // Reset pulse the cycle after a read grant
    push(0, 1'b0, 1'b0, 12'h010, 16'h0000);
    push(0, 1'b0, 1'b0, 12'h001, 16'h0000);
    push(1, 1'b1, 1'b0, 12'h000, 16'h0000);
    push(1, 1'b0, 1'b0, 12'h002, 16'h0000);
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    step();
    rst_n = 1'b1;
    run_drain();

    // Randomised traffic over a small address window
    for (int k = 0; k < 200; k++) begin
      for (int p = 0; p < 2; p++) begin
        push(p, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 15)), 16'($urandom));
      end
    end
    run_drain();

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("scoreboard_empty[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit synchronous memory between two requesters: port A (instruction fetch) and port B (data load/store).
- Issues at most one memory access per clock.
- Uses round-robin or fixed priority, and routes each read response back to the requester that issued it.
- Sits between the processor front-end/LSU and the memory.

Parameters:
- ADDR_WIDTH, 12, halfword address width; must match memory depth 2**ADDR_WIDTH.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port A always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A access request; held until a_gnt.
- a_we  in  1  port A write (1) / read (0); stable while a_req.
- a_addr  in  ADDR_WIDTH  port A halfword address.
- a_wdata  in  16  port A write data.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  16  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B.
- mem_en  out  1  memory enable.
- mem_rd_en  out  1  memory read enable.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  16  memory write data.
- mem_dout  in  16  memory registered read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - last_grant = B, so A wins the first conflict.
  - rd_owner = NONE.
  - a_rvalid = b_rvalid = 0.
- While rst_n is low, a_gnt, b_gnt, mem_en, mem_rd_en and mem_wr_en are forced 0 combinationally.
- Grant is combinational in the same cycle as the request:
  - Only one requester active: that requester is granted.
  - Both active, FIXED_PRIO=1: A is granted.
  - Both active, FIXED_PRIO=0: the port not in last_grant is granted.
  - Neither active: no grant, mem_en=0.
- On a grant:
  - mem_en=1.
  - mem_wr_en = we, mem_rd_en = ~we.
  - mem_addr and mem_din are muxed from the granted port.
  - last_grant updates to the granted port at the clock edge.
- With no grant, mem_addr and mem_din are don't-care; the bench checks only mem_en=0.
- Handshake:
  - A requester holds req, we, addr and wdata until it sees gnt high at a rising edge.
  - It may drop or change them in the cycle after gnt.
  - A non-granted requester sees gnt=0 and must hold.
- Read latency is 1 cycle:
  - A read granted in cycle N produces rvalid=1 for exactly cycle N+1 on the granted port only.
  - rdata = mem_dout in that cycle.
  - rd_owner (registered) records the port granted a read in cycle N and selects the rvalid target in N+1.
- rdata on both ports always follows mem_dout; it is meaningful only while rvalid is high.
- Writes produce no response; the write is complete at the edge ending the grant cycle.
- Back-to-back operation:
  - Grants may occur every cycle.
  - A read grant in N+1 is independent of the rvalid in N+1; the pipeline carries the response.
- Read after write to the same address in consecutive grants returns the new data.
- Starvation bound in round-robin mode: a continuously requesting port is granted within 2 cycles.
- Reset asserted mid-operation:
  - A pending rvalid is cancelled and rd_owner is cleared.
  - The in-flight memory write at that edge is not guaranteed.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_A, OWN_B}.
  - typedef struct mem_req_t {we, addr, wdata}; its addr width comes from a package constant MEM_ADDR_WIDTH = 12.
- Sub-module rr_arbiter2:
  - Inputs: req[1:0], FIXED_PRIO.
  - Outputs: one-hot gnt[1:0].
  - Owns the last_grant register.
- The top level holds the request muxes and the rd_owner/rvalid pipeline.

Test Plan:
- Reset, then a_req read at addr 0x010 with memory preloaded 0xBEEF -> a_gnt same cycle, mem_rd_en=1, mem_addr=0x010; next cycle a_rvalid=1, a_rdata=0xBEEF; b_rvalid=0.
- b_req write 0x1234 to 0x020, then b read of 0x020 in the next cycle -> both granted back-to-back; b_rvalid one cycle after the read grant with 0x1234.
- a and b both request continuously, round-robin mode -> grants alternate A,B,A,B starting with A; each rvalid goes to the correct port with that port's data (A addr 0x001=0x0A0A, B addr 0x002=0x0B0B).
- Same conflict with FIXED_PRIO=1 -> A granted every cycle; b_gnt stays 0 until a_req drops, then B granted the same cycle.
- Idle cycles with no requests -> mem_en=0, no rvalid, last_grant unchanged; the next conflict still favours the port not last granted.
- rst_n pulsed low for 1 cycle the cycle after a read grant -> a_rvalid never asserts; all grants are 0 while rst_n is low; normal operation resumes after release with A winning the first conflict.
